// File: rtl/i2s_rx_deserializer.sv
// i2s_rx_deserializer: Philips I2S receiver turning serial mic data into left/right pairs on valid/ready
module i2s_rx_deserializer #(
   parameter int   DATA_WIDTH     = 24,
   parameter int   SCKS_PER_FRAME = 32,
   parameter int   SYNC_STAGES    = 2,
   parameter logic WS_POL         = 1'b0
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  en_i,
   input  logic                  sck_i,
   input  logic                  ws_i,
   input  logic                  sd_i,
   output logic [DATA_WIDTH-1:0] left_o,
   output logic [DATA_WIDTH-1:0] right_o,
   output logic                  valid_o,
   input  logic                  ready_i,
   output logic                  overrun_o,
   output logic                  frame_err_o
);
   // A slot carries at most SCKS_PER_FRAME-1 data bits after the one-bit delay slot
   localparam int NBITS = (DATA_WIDTH < SCKS_PER_FRAME) ? DATA_WIDTH : SCKS_PER_FRAME - 1;
   localparam int CW = $clog2(NBITS + 1);
   localparam logic [1:0] S_SYNC = 2'd0, S_CAPT = 2'd1, S_DONE = 2'd2, S_WAIT = 2'd3;

   logic                   sck_prev_q;
   logic [SYNC_STAGES-1:0] rise_q, ws_pipe_q, sd_pipe_q;
   logic                   ws_prev_q;
   logic [1:0]             state_q, state_d;
   logic                   ch_q, ch_d;
   logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
   logic [DATA_WIDTH-1:0]  shift_q, shift_d, left_hold_q, left_hold_d;
   logic                   left_ok_q, left_ok_d;
   logic [DATA_WIDTH-1:0]  left_q, left_d, right_q, right_d;
   logic                   valid_q, valid_d, overrun_q, overrun_d, frame_err_q, frame_err_d;
   logic                   stb, ws_s, sd_s, ws_chg, pair_done, load;

   assign stb    = rise_q[SYNC_STAGES-1];
   assign ws_s   = ws_pipe_q[SYNC_STAGES-1];
   assign sd_s   = sd_pipe_q[SYNC_STAGES-1];
   assign ws_chg = stb & (ws_s != ws_prev_q);

   // Edge-detect sck and delay strobe/ws so they line up with the synchronised sd
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         sck_prev_q <= 1'b0;
         rise_q     <= '0;
         ws_pipe_q  <= '0;
         sd_pipe_q  <= '0;
         ws_prev_q  <= 1'b0;
      end else begin
         sck_prev_q <= sck_i;
         rise_q     <= SYNC_STAGES'({rise_q, sck_i & ~sck_prev_q});
         ws_pipe_q  <= SYNC_STAGES'({ws_pipe_q, ws_i});
         sd_pipe_q  <= SYNC_STAGES'({sd_pipe_q, sd_i});
         if (stb) ws_prev_q <= ws_s;
      end

   // Word framing FSM; a low enable overrides everything and forces resync
   always_comb begin
      state_d     = state_q;
      ch_d        = ch_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      left_hold_d = left_hold_q;
      left_ok_d   = left_ok_q;
      pair_done   = 1'b0;
      frame_err_d = 1'b0;
      case (state_q)
         S_SYNC:
            if (ws_chg && ws_s == WS_POL) begin
               ch_d      = 1'b0;
               bit_cnt_d = '0;
               shift_d   = '0;
               state_d   = S_CAPT;
            end
         S_CAPT:
            if (ws_chg) begin
               frame_err_d = 1'b1;
               left_ok_d   = 1'b0;
               state_d     = S_SYNC;
            end else if (stb) begin
               shift_d   = DATA_WIDTH'({shift_q, sd_s});
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (bit_cnt_q == CW'(NBITS - 1)) state_d = S_DONE;
            end
         S_DONE: begin
            if (ch_q) begin
               pair_done = 1'b1;
               left_ok_d = 1'b0;
            end else begin
               left_hold_d = shift_q;
               left_ok_d   = 1'b1;
            end
            state_d = S_WAIT;
         end
         default:
            if (ws_chg) begin
               ch_d      = ws_s != WS_POL;
               bit_cnt_d = '0;
               shift_d   = '0;
               state_d   = (ws_s != WS_POL && !left_ok_q) ? S_SYNC : S_CAPT;
            end
      endcase
      if (!en_i) begin
         state_d     = S_SYNC;
         left_ok_d   = 1'b0;
         pair_done   = 1'b0;
         frame_err_d = 1'b0;
      end
   end

   // Output register: load when empty or draining this cycle, otherwise drop and flag overrun
   always_comb begin
      load      = pair_done & (~valid_q | ready_i);
      valid_d   = load | (valid_q & ~ready_i);
      overrun_d = pair_done & ~load;
      left_d    = load ? left_hold_q : left_q;
      right_d   = load ? shift_q : right_q;
   end

   // State and output registers
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         state_q     <= S_SYNC;
         ch_q        <= 1'b0;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         left_hold_q <= '0;
         left_ok_q   <= 1'b0;
         left_q      <= '0;
         right_q     <= '0;
         valid_q     <= 1'b0;
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ch_q        <= ch_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         left_hold_q <= left_hold_d;
         left_ok_q   <= left_ok_d;
         left_q      <= left_d;
         right_q     <= right_d;
         valid_q     <= valid_d;
         overrun_q   <= overrun_d;
         frame_err_q <= frame_err_d;
      end

   assign left_o      = left_q;
   assign right_o     = right_q;
   assign valid_o     = valid_q;
   assign overrun_o   = overrun_q;
   assign frame_err_o = frame_err_q;
endmodule
